// File: rtl/hcsr04_pkg.sv
// Shared types and 100 MHz default timing for the HC-SR04 responder model.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrigHi,
        StBurst,
        StEcho,
        StRecover
    } state_e;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefTrigMinCyc = 1000;     // 10 us
    localparam int unsigned DefBurstCyc   = 20000;    // 200 us
    localparam int unsigned DefCycPerCm   = 5800;     // 58 us
    localparam int unsigned DefMaxCm      = 400;
    localparam int unsigned DefTimeoutCyc = 3800000;  // 38 ms
    localparam int unsigned DefRecoverCyc = 100000;   // 1 ms

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hcsr04_responder_trig_sync.sv
// Trig synchronizer with rise/fall detect on the synchronized signal.
module hcsr04_responder_trig_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic trig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_q;

    // Shift raw trig through the synchronizer; trig_q trails trig_s by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            trig_q <= 1'b0;
        end else begin
            sync_q[0] <= trig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            trig_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge strobes are combinational so the FSM acts on them the same cycle.
    always_comb begin
        trig_s = sync_q[SYNC_STAGES-1];
        rise   = trig_s & ~trig_q;
        fall   = ~trig_s & trig_q;
    end

endmodule

// File: rtl/hcsr04_responder.sv
// HC-SR04 responder: accepts a long-enough trig pulse and answers with an
// echo pulse whose width encodes the distance latched at trig acceptance.
module hcsr04_responder
    import hcsr04_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DefSyncStages,
    parameter int unsigned TRIG_MIN_CYC = DefTrigMinCyc,
    parameter int unsigned BURST_CYC    = DefBurstCyc,
    parameter int unsigned CYC_PER_CM   = DefCycPerCm,
    parameter int unsigned MAX_CM       = DefMaxCm,
    parameter int unsigned TIMEOUT_CYC  = DefTimeoutCyc,
    parameter int unsigned RECOVER_CYC  = DefRecoverCyc
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       short_trig,
    output logic [7:0] meas_cnt
);

    localparam int unsigned MaxCyc = max2(max2(TRIG_MIN_CYC, BURST_CYC),
                                          max2(max2(TIMEOUT_CYC, RECOVER_CYC), CYC_PER_CM));
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] TrigMin  = CntW'(TRIG_MIN_CYC);
    // Burst spans the fall-detect cycle plus BURST_CYC, giving echo rise at
    // E + SYNC_STAGES + BURST_CYC + 1 for a trig first sampled low at edge E.
    localparam logic [CntW-1:0] BurstEnd = CntW'(BURST_CYC);
    localparam logic [CntW-1:0] PreEnd   = CntW'(CYC_PER_CM - 1);
    localparam logic [CntW-1:0] TmoEnd   = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] RecEnd   = CntW'(RECOVER_CYC - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    logic trig_s;
    logic rise;
    logic fall;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;      // trig width, burst, prescaler, timeout, recover
    logic [8:0]      cm_q, cm_d;        // remaining centimetres in echo
    logic            tmo_q, tmo_d;      // latched distance was out of range
    logic            echo_q, echo_d;
    logic            busy_q, busy_d;
    logic            short_q, short_d;
    logic [7:0]      meas_q, meas_d;
    logic            dist_bad;
    logic            echo_done;

    hcsr04_responder_trig_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk   (clk),
        .rst   (rst),
        .trig  (trig),
        .trig_s(trig_s),
        .rise  (rise),
        .fall  (fall)
    );

    assign dist_bad = (distance_cm == 9'd0) || (32'(distance_cm) > MAX_CM);

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cm_q    <= '0;
            tmo_q   <= 1'b0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cm_q    <= cm_d;
            tmo_q   <= tmo_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            short_q <= short_d;
            meas_q  <= meas_d;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cm_d      = cm_q;
        tmo_d     = tmo_q;
        short_d   = 1'b0;
        meas_d    = meas_q;
        echo_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StTrigHi;
                    cnt_d   = CntOne;
                end
            end
            StTrigHi: begin
                if (fall) begin
                    cnt_d = '0;
                    if (cnt_q >= TrigMin) begin
                        state_d = StBurst;
                        cm_d    = distance_cm;
                        tmo_d   = dist_bad;
                    end else begin
                        state_d = StIdle;
                        short_d = 1'b1;
                    end
                end else if (trig_s && (cnt_q < TrigMin)) begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBurst: begin
                if (cnt_q == BurstEnd) begin
                    state_d = StEcho;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StEcho: begin
                if (tmo_q) begin
                    if (cnt_q == TmoEnd) begin
                        echo_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else if (cnt_q == PreEnd) begin
                    // One centimetre elapsed; cm_q is never zero on the valid path.
                    cnt_d = '0;
                    if (cm_q == 9'd1) begin
                        echo_done = 1'b1;
                    end else begin
                        cm_d = cm_q - 9'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
                if (echo_done) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                    meas_d  = meas_q + 8'd1;
                end
            end
            StRecover: begin
                if (cnt_q == RecEnd) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        echo_d = (state_d == StEcho);
        busy_d = (state_d == StBurst) || (state_d == StEcho) || (state_d == StRecover);
    end

    assign echo       = echo_q;
    assign busy       = busy_q;
    assign short_trig = short_q;
    assign meas_cnt   = meas_q;

endmodule

// File: tb/tb_hcsr04_responder.sv
// Directed + randomized bench for hcsr04_responder with scaled-down timing.
module tb_hcsr04_responder;

    localparam int SyncStages = 2;
    localparam int TrigMin    = 10;
    localparam int BurstCyc   = 20;
    localparam int CycPerCm   = 5;
    localparam int MaxCm      = 400;
    localparam int TimeoutCyc = 3000;
    localparam int RecoverCyc = 50;
    localparam int RiseOff    = SyncStages + BurstCyc + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       short_trig;
    logic [7:0] meas_cnt;

    int total = 0;
    int bad   = 0;
    int exp_meas = 0;

    // Observations from the last watched transaction (offsets from edge E).
    int m_rise, m_fall, m_brise, m_bfall, m_short, m_pulses, m_done;

    hcsr04_responder #(
        .SYNC_STAGES (SyncStages),
        .TRIG_MIN_CYC(TrigMin),
        .BURST_CYC   (BurstCyc),
        .CYC_PER_CM  (CycPerCm),
        .MAX_CM      (MaxCm),
        .TIMEOUT_CYC (TimeoutCyc),
        .RECOVER_CYC (RecoverCyc)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .distance_cm(distance_cm),
        .echo       (echo),
        .busy       (busy),
        .short_trig (short_trig),
        .meas_cnt   (meas_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int exp_width(input int d);
        return (d >= 1 && d <= MaxCm) ? d * CycPerCm : TimeoutCyc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive a trig pulse of 'hi' sampled cycles, then watch until busy falls.
    // Offsets k count edges after E, the first edge that samples trig low.
    task automatic watch(input int hi, input int d, input int budget,
                         input int on1, input int off1, input int on2, input int off2,
                         input int on3, input int dchg_off, input int dchg_val,
                         input int abort_off);
        int pe, pb;
        distance_cm = 9'(d);
        trig = 1'b1;
        repeat (hi) step();
        trig = 1'b0;
        m_rise = -1; m_fall = -1; m_brise = -1; m_bfall = -1;
        m_short = 0; m_pulses = 0; m_done = 0;
        pe = 0; pb = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (echo && pe == 0) begin
                m_pulses++;
                if (m_rise < 0) m_rise = k;
            end
            if (!echo && pe == 1 && m_fall < 0) m_fall = k;
            if (busy && pb == 0 && m_brise < 0) m_brise = k;
            if (!busy && pb == 1) begin
                m_bfall = k;
                m_done  = 1;
            end
            if (short_trig) m_short++;
            pe = int'(echo);
            pb = int'(busy);
            if (k == on1 || k == on2 || k == on3) trig = 1'b1;
            if (k == off1 || k == off2) trig = 1'b0;
            if (k == dchg_off) distance_cm = 9'(dchg_val);
            if (k == abort_off) begin
                rst = 1'b1;
                break;
            end
            if (m_done == 1) break;
        end
    endtask

    task automatic meas(input string tag, input int hi, input int d);
        watch(hi, d, RiseOff + exp_width(d) + RecoverCyc + 20, -1, -1, -1, -1, -1, -1, 0, -1);
        exp_meas++;
    endtask

    task automatic check_meas(input string tag, input int d);
        chk({tag, "_done"}, m_done, 1);
        chk({tag, "_busy_rise"}, m_brise, SyncStages);
        chk({tag, "_echo_rise"}, m_rise, RiseOff);
        chk({tag, "_width"}, m_fall - m_rise, exp_width(d));
        chk({tag, "_recover"}, m_bfall - m_fall, RecoverCyc);
        chk({tag, "_pulses"}, m_pulses, 1);
        chk({tag, "_short"}, m_short, 0);
        chk({tag, "_meas_cnt"}, int'(meas_cnt), exp_meas % 256);
    endtask

    initial begin
        int d, nd, hi, off, bsum;
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = '0;
        repeat (3) step();
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_short", int'(short_trig), 0);
        chk("rst_meas", int'(meas_cnt), 0);
        rst = 1'b0;
        step();

        // Basic measurement: 12-cycle trig, 7 cm.
        meas("t1", 12, 7);
        check_meas("t1", 7);

        // Short trig rejected; minimum-length trig accepted.
        watch(9, 7, 40, -1, -1, -1, -1, -1, -1, 0, -1);
        chk("t2_short_pulse", m_short, 1);
        chk("t2_echo", m_pulses, 0);
        chk("t2_busy", m_brise, -1);
        chk("t2_meas_cnt", int'(meas_cnt), exp_meas % 256);
        meas("t2_min", TrigMin, 3);
        check_meas("t2_min", 3);

        // Distance boundaries.
        meas("t3_d0", 12, 0);
        check_meas("t3_d0", 0);
        meas("t3_d401", 12, 401);
        check_meas("t3_d401", 401);
        meas("t3_d400", 12, 400);
        check_meas("t3_d400", 400);
        meas("t3_d1", 12, 1);
        check_meas("t3_d1", 1);

        // Retrigger in ECHO and RECOVER, then trig held across RECOVER end.
        watch(12, 7, 200, 25, 40, 65, 80, 95, -1, 0, -1);
        exp_meas++;
        check_meas("t4", 7);
        bsum = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            bsum += int'(busy) + int'(echo) + int'(short_trig);
        end
        chk("t4_hold_idle", bsum, 0);
        trig = 1'b0;
        repeat (4) step();
        meas("t4_after", 12, 9);
        check_meas("t4_after", 9);

        // Reset mid-echo, then a clean measurement.
        watch(12, 20, 400, -1, -1, -1, -1, -1, -1, 0, 40);
        chk("t5_echo_before", int'(echo), 1);
        step();
        chk("t5_echo_rst", int'(echo), 0);
        chk("t5_busy_rst", int'(busy), 0);
        chk("t5_meas_rst", int'(meas_cnt), 0);
        exp_meas = 0;
        rst = 1'b0;
        step();
        meas("t5_after", 12, 13);
        check_meas("t5_after", 13);

        // 256 back-to-back random measurements with distance changed in BURST.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        exp_meas = 0;
        for (int n = 0; n < 256; n++) begin
            d   = $urandom_range(1, 24);
            nd  = $urandom_range(0, 511);
            hi  = $urandom_range(TrigMin, TrigMin + 4);
            off = $urandom_range(SyncStages, SyncStages + BurstCyc);
            watch(hi, d, RiseOff + exp_width(d) + RecoverCyc + 20,
                  -1, -1, -1, -1, -1, off, nd, -1);
            exp_meas++;
            check_meas("t6", d);
        end
        chk("t6_wrap", int'(meas_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
